// File: rtl/lamp_pkg.sv
// Shared types for the lamp sequencer: pattern modes and controller states.
package lamp_pkg;

    typedef enum logic [1:0] {
        LAMP_OFF    = 2'd0,
        LAMP_ALL_ON = 2'd1,
        LAMP_CHASE  = 2'd2,
        LAMP_BLINK  = 2'd3
    } lamp_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } lamp_state_e;

endpackage

// File: rtl/lamp_step_timer.sv
// Step prescaler: counts RUN cycles up to period-1, flags the boundary cycle
// and emits a registered one-cycle tick after each boundary.
module lamp_step_timer #(
    parameter int PERIOD_W = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                run,
    input  logic                clear,
    input  logic [PERIOD_W-1:0] period,
    output logic                at_bound,
    output logic                tick
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                tick_q, tick_d;

    // period is never zero, so period-1 cannot wrap
    always_comb begin
        at_bound = (cnt_q == (period - PERIOD_W'(1)));
        cnt_d    = cnt_q + PERIOD_W'(1);
        if (!run || clear || at_bound) begin
            cnt_d = '0;
        end
        tick_d = run && at_bound;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/lamp_sequencer.sv
// Lamp bank sequencer: host-selected patterns paced by a step prescaler;
// mode changes are only taken on step boundaries or while idle.
//   state   | meaning
//   ST_IDLE | lamps dark, counters cleared, always ready for a request
//   ST_RUN  | pattern running, requests taken only on the boundary cycle
module lamp_sequencer
    import lamp_pkg::*;
#(
    parameter int NUM_LAMPS    = 11,
    parameter int PERIOD_W     = 16,
    parameter int RESET_PERIOD = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [PERIOD_W-1:0]  period,
    input  logic                 mode_valid,
    output logic                 mode_ready,
    output logic [NUM_LAMPS-1:0] lamps,
    output logic                 step_tick,
    output logic                 busy
);

    localparam int IDX_W = (NUM_LAMPS > 1) ? $clog2(NUM_LAMPS) : 1;

    lamp_state_e           state_q, state_d;
    lamp_mode_e            mode_q, mode_d;
    logic [PERIOD_W-1:0]   period_q, period_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  phase_q, phase_d;
    logic [NUM_LAMPS-1:0]  lamps_q, lamps_d;
    logic                  at_bound;
    logic                  run;
    logic                  accept;

    function automatic logic [NUM_LAMPS-1:0] pattern(input lamp_mode_e m,
                                                     input logic [IDX_W-1:0] i,
                                                     input logic ph);
        logic [NUM_LAMPS-1:0] p;
        case (m)
            LAMP_ALL_ON: p = '1;
            LAMP_CHASE:  p = NUM_LAMPS'(1) << i;
            LAMP_BLINK:  p = ph ? '1 : '0;
            default:     p = '0;
        endcase
        return p;
    endfunction

    assign run        = (state_q == ST_RUN) && enable;
    assign mode_ready = (state_q == ST_IDLE) || at_bound;
    assign accept     = mode_valid && mode_ready;
    assign busy       = (state_q == ST_RUN);
    assign lamps      = lamps_q;

    lamp_step_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .run      (run),
        .clear    (accept),
        .period   (period_q),
        .at_bound (at_bound),
        .tick     (step_tick)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        period_d = period_q;
        idx_d    = idx_q;
        phase_d  = phase_q;
        if (accept) begin
            mode_d   = lamp_mode_e'(mode);
            period_d = (period == '0) ? PERIOD_W'(1) : period;
        end
        // a dropped enable wins over both a step and an accepted request
        if (!enable) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            phase_d = 1'b0;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_RUN;
            idx_d   = '0;
            phase_d = 1'b0;
        end else if (accept) begin
            idx_d   = '0;
            phase_d = 1'b0;
        end else if (at_bound) begin
            if (mode_q == LAMP_CHASE) begin
                idx_d = (idx_q == IDX_W'(NUM_LAMPS - 1)) ? '0 : idx_q + IDX_W'(1);
            end
            if (mode_q == LAMP_BLINK) begin
                phase_d = ~phase_q;
            end
        end
        lamps_d = (state_d == ST_RUN) ? pattern(mode_d, idx_d, phase_d) : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            mode_q   <= LAMP_OFF;
            period_q <= PERIOD_W'(RESET_PERIOD);
            idx_q    <= '0;
            phase_q  <= 1'b0;
            lamps_q  <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            period_q <= period_d;
            idx_q    <= idx_d;
            phase_q  <= phase_d;
            lamps_q  <= lamps_d;
        end
    end

endmodule

// File: tb/tb_lamp_sequencer.sv
// Self-checking bench for lamp_sequencer: a cycle model pushes expected
// outputs into a scoreboard that is popped after each clock edge.
module tb_lamp_sequencer;

    localparam int N  = 11;
    localparam int PW = 16;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [1:0]    mode;
    logic [PW-1:0] period;
    logic          mode_valid;
    logic          mode_ready;
    logic [N-1:0]  lamps;
    logic          step_tick;
    logic          busy;

    typedef struct {
        logic [N-1:0] lamps;
        logic         tick;
        logic         busy;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    bit   m_run;
    int   m_mode;
    int   m_period;
    int   m_cnt;
    int   m_idx;
    bit   m_phase;

    always #5 clock = ~clock;

    lamp_sequencer #(
        .NUM_LAMPS    (N),
        .PERIOD_W     (PW),
        .RESET_PERIOD (1)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .mode       (mode),
        .period     (period),
        .mode_valid (mode_valid),
        .mode_ready (mode_ready),
        .lamps      (lamps),
        .step_tick  (step_tick),
        .busy       (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] m_pat(input int md, input int ix, input bit ph);
        logic [N-1:0] one;
        one = 1;
        case (md)
            0:       return '0;
            1:       return '1;
            2:       return one << ix;
            default: return ph ? '1 : '0;
        endcase
    endfunction

    task automatic model_reset();
        m_run    = 0;
        m_mode   = 0;
        m_period = 1;
        m_cnt    = 0;
        m_idx    = 0;
        m_phase  = 0;
    endtask

    // inputs are already driven; predict the edge, push, clock, pop, compare
    task automatic cyc();
        bit   rdy, acc, bnd;
        exp_t e;
        rdy = !m_run || (m_cnt == m_period - 1);
        check_val("mode_ready", mode_ready, rdy);
        acc = mode_valid && rdy;
        bnd = m_run && (m_cnt == m_period - 1);
        e.tick = 0;
        if (acc) begin
            m_mode   = mode;
            m_period = (period == 0) ? 1 : int'(period);
        end
        if (!enable) begin
            m_run = 0; m_cnt = 0; m_idx = 0; m_phase = 0;
        end else if (!m_run) begin
            m_run = 1; m_cnt = 0; m_idx = 0; m_phase = 0;
        end else if (acc) begin
            m_cnt = 0; m_idx = 0; m_phase = 0;
            e.tick = 1;
        end else if (bnd) begin
            m_cnt  = 0;
            e.tick = 1;
            if (m_mode == 2) m_idx = (m_idx + 1) % N;
            if (m_mode == 3) m_phase = !m_phase;
        end else begin
            m_cnt++;
        end
        e.lamps = m_run ? m_pat(m_mode, m_idx, m_phase) : '0;
        e.busy  = m_run;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        check_val("lamps", lamps, e.lamps);
        check_val("step_tick", step_tick, e.tick);
        check_val("busy", busy, e.busy);
    endtask

    task automatic hold_until_accept();
        bit got;
        got = 0;
        mode_valid = 1;
        for (int i = 0; i < 20 && !got; i++) begin
            got = !m_run || (m_cnt == m_period - 1);
            cyc();
        end
        mode_valid = 0;
        check_val("accept_seen", got, 1);
    endtask

    initial begin
        reset_n    = 0;
        enable     = 0;
        mode_valid = 0;
        mode       = 0;
        period     = 0;
        model_reset();
        #22;
        check_val("rst_lamps", lamps, 0);
        check_val("rst_tick", step_tick, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_ready", mode_ready, 1);
        @(posedge clock);
        #1;
        reset_n = 1;

        // CHASE at period 3, set up from IDLE
        mode = 2; period = 3; mode_valid = 1;
        cyc();
        mode_valid = 0; enable = 1;
        cyc();
        check_val("chase_first", lamps, 11'h001);
        repeat (3) cyc();
        check_val("chase_second", lamps, 11'h002);
        repeat (30) cyc();
        check_val("chase_wrap", lamps, 11'h001);
        for (int i = 0; i < 40 && m_idx != 5; i++) cyc();
        check_val("chase_idx5", lamps, 11'h020);

        // asynchronous reset in the middle of a step
        reset_n = 0;
        #1;
        check_val("arst_lamps", lamps, 0);
        check_val("arst_busy", busy, 0);
        check_val("arst_ready", mode_ready, 1);
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1;

        // BLINK period 4, then a held ALL_ON request waits for the boundary
        mode = 3; period = 4; mode_valid = 1; enable = 1;
        cyc();
        mode_valid = 0;
        repeat (6) cyc();
        mode = 1;
        hold_until_accept();
        check_val("all_on_now", lamps, 11'h7FF);
        repeat (5) cyc();
        check_val("all_on_stays", lamps, 11'h7FF);

        // period 0 clamps to 1: BLINK toggles every cycle
        mode = 3; period = 0;
        hold_until_accept();
        repeat (8) cyc();

        // CHASE period 5, drop enable at cnt 1, then re-enable
        mode = 2; period = 5;
        hold_until_accept();
        repeat (7) cyc();
        for (int i = 0; i < 10 && m_cnt != 1; i++) cyc();
        enable = 0;
        cyc();
        check_val("drop_lamps", lamps, 0);
        check_val("drop_busy", busy, 0);
        enable = 1;
        cyc();
        check_val("reen_lamps", lamps, 11'h001);
        repeat (4) cyc();
        check_val("reen_hold", lamps, 11'h001);
        cyc();
        check_val("reen_step", lamps, 11'h002);

        // boundary cycle with a request and enable low together
        for (int i = 0; i < 10 && m_cnt != m_period - 1; i++) cyc();
        mode = 1; period = 5; mode_valid = 1; enable = 0;
        cyc();
        check_val("bnd_off_lamps", lamps, 0);
        check_val("bnd_off_tick", step_tick, 0);
        mode_valid = 0;
        cyc();
        enable = 1;
        cyc();
        check_val("bnd_off_mode_kept", lamps, 11'h7FF);

        // random traffic
        repeat (400) begin
            enable     = ($urandom_range(0, 15) != 0);
            mode_valid = ($urandom_range(0, 2) == 0);
            mode       = 2'($urandom_range(0, 3));
            period     = PW'($urandom_range(0, 4));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
